// File: rtl/tmr_pkg.sv
// tmr_pkg: shared timer widths, register map and arbiter lock-state type
package tmr_pkg;
  localparam int TMR_AW = 5;
  localparam int TMR_DW = 32;
  localparam logic [4:0] TMR_CTRL = 5'h00;
  localparam logic [4:0] TMR_LOAD = 5'h04;
  localparam logic [4:0] TMR_CNT = 5'h08;
  localparam logic [4:0] TMR_STAT = 5'h0c;
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED0 = 2'd1, LOCKED1 = 2'd2} tmr_arb_st_t;
  function automatic logic [1:0] st_own(tmr_arb_st_t s);
    return {s == LOCKED1, s == LOCKED0};
  endfunction
endpackage

// File: rtl/reg_we.sv
// reg_we: register with load enable; ports clk, rstn (async low), en, d -> q
module reg_we #(
  parameter int w = 1,
  parameter logic [w-1:0] rv = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= rv;
    else if (en) q <= d;
endmodule

// File: rtl/tmr_arb_rr2.sv
// tmr_arb_rr2: 2-way round-robin grant; req, last (previous winner), mask (lock filter) -> gnt
module tmr_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);
  logic [1:0] r;
  assign r = req & mask;
  assign gnt = &r ? (last ? 2'b01 : 2'b10) : r;
endmodule

// File: rtl/tmr_arb.sv
// tmr_arb: two-requester arbiter for the timer core register bus
// Ports: req/lock/addr_i/we_i/wd_i from requesters, gnt/rvalid/rd_o back to them,
// addr/we/wd registered to the core, rd from the core, lock_own status.
// Define TMR_ARB_LOCK_EN to build the bus lock with lock_to idle timeout.
module tmr_arb
  import tmr_pkg::*;
#(
  parameter int aw = TMR_AW,
  parameter int dw = TMR_DW,
  parameter int lock_to = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    req,
  input  logic [1:0]    lock,
  input  logic [aw-1:0] addr_0,
  input  logic [aw-1:0] addr_1,
  input  logic          we_0,
  input  logic          we_1,
  input  logic [dw-1:0] wd_0,
  input  logic [dw-1:0] wd_1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [dw-1:0] rd_o,
  output logic [aw-1:0] addr,
  output logic          we,
  output logic [dw-1:0] wd,
  input  logic [dw-1:0] rd,
  output logic [1:0]    lock_own
);
  tmr_arb_st_t st;
  logic last;
  logic acc;
  logic sel;
  assign lock_own = st_own(st);
  tmr_arb_rr2 u_rr (
    .req (req),
    .last(last),
    .mask(lock_own == 2'b00 ? 2'b11 : lock_own),
    .gnt (gnt)
  );
  assign acc = |gnt;
  assign sel = gnt[1];
  reg_we #(.w(aw)) u_addr (.clk(clk), .rstn(rstn), .en(acc), .d(sel ? addr_1 : addr_0), .q(addr));
  reg_we #(.w(dw)) u_wd (.clk(clk), .rstn(rstn), .en(acc), .d(sel ? wd_1 : wd_0), .q(wd));
  reg_we #(.w(1)) u_we (.clk(clk), .rstn(rstn), .en(1'b1), .d(acc & (sel ? we_1 : we_0)), .q(we));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      last <= 1'b1;
      rvalid <= 2'b00;
    end else begin
      rvalid <= gnt;
      if (acc) last <= sel;
    end
  assign rd_o = |rvalid ? rd : '0;
`ifdef TMR_ARB_LOCK_EN
  localparam int cw = lock_to > 1 ? $clog2(lock_to) : 1;
  logic [cw-1:0] cnt;
  logic lk;
  assign lk = sel ? lock[1] : lock[0];
  // while locked only the owner can be granted, so any accept is an owner accept
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st <= UNLOCKED;
      cnt <= '0;
    end else if (st == UNLOCKED) begin
      cnt <= '0;
      if (acc && lk) st <= sel ? LOCKED1 : LOCKED0;
    end else if (acc) begin
      cnt <= '0;
      if (!lk) st <= UNLOCKED;
    end else if (cnt == cw'(lock_to - 1)) begin
      cnt <= '0;
      st <= UNLOCKED;
    end else begin
      cnt <= cnt + 1'b1;
    end
`else
  logic unused_lock;
  assign unused_lock = ^lock ^ (lock_to > 0);
  assign st = UNLOCKED;
`endif
endmodule

// File: tb/tb_tmr_arb.sv
// tb_tmr_arb: directed scoreboard bench for tmr_arb (lock expectations follow TMR_ARB_LOCK_EN)
module tb_tmr_arb;
  logic clk;
  logic rstn;
  logic [1:0] req, lock, gnt, rvalid, lock_own;
  logic [4:0] addr_0, addr_1, addr;
  logic we_0, we_1, we;
  logic [31:0] wd_0, wd_1, wd, rd, rd_o;
  int total = 0;
  int passed = 0;
`ifdef TMR_ARB_LOCK_EN
  localparam bit lk = 1'b1;
`else
  localparam bit lk = 1'b0;
`endif
  typedef struct packed {
    logic [1:0]  ov;
    logic [31:0] rd;
    logic        we;
    logic [4:0]  a;
    logic [31:0] wd;
  } rsp_t;
  logic [3:0] gq[$];
  rsp_t rq[$];
  tmr_arb #(.aw(5), .dw(32), .lock_to(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock),
    .addr_0(addr_0), .addr_1(addr_1), .we_0(we_0), .we_1(we_1),
    .wd_0(wd_0), .wd_1(wd_1), .gnt(gnt), .rvalid(rvalid), .rd_o(rd_o),
    .addr(addr), .we(we), .wd(wd), .rd(rd), .lock_own(lock_own)
  );
  function automatic logic [31:0] core_rd(input logic [4:0] a);
    return 32'h1234_5678 ^ {a, 27'd0};
  endfunction
  assign rd = core_rd(addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input logic [1:0] r, input logic [1:0] l,
                      input logic [4:0] a0, input logic w0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic w1, input logic [31:0] d1,
                      input logic [1:0] eg, input logic [1:0] elo, input bit keep);
    @(posedge clk);
    #1;
    req = r; lock = l;
    addr_0 = a0; we_0 = w0; wd_0 = d0;
    addr_1 = a1; we_1 = w1; wd_1 = d1;
    gq.push_back({eg, elo});
    if (keep && eg != 2'b00)
      rq.push_back(eg[1] ? rsp_t'{eg, core_rd(a1), w1, a1, d1} : rsp_t'{eg, core_rd(a0), w0, a0, d0});
  endtask
  task automatic idle(input logic [1:0] elo);
    step(2'b00, 2'b00, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 2'b00, elo, 1'b1);
  endtask
  always @(negedge clk) begin
    logic [3:0] e;
    rsp_t p;
    if (gq.size() != 0) begin
      e = gq.pop_front();
      chk("gnt", {30'd0, gnt}, {30'd0, e[3:2]});
      chk("lock_own", {30'd0, lock_own}, {30'd0, e[1:0]});
    end
    if (|rvalid) begin
      if (rq.size() == 0) chk("rvalid_unexpected", {30'd0, rvalid}, 32'd0);
      else begin
        p = rq.pop_front();
        chk("rvalid", {30'd0, rvalid}, {30'd0, p.ov});
        chk("rd_o", rd_o, p.rd);
        chk("we", {31'd0, we}, {31'd0, p.we});
        chk("addr", {27'd0, addr}, {27'd0, p.a});
        chk("wd", wd, p.wd);
      end
    end else begin
      chk("idle_we", {31'd0, we}, 32'd0);
      chk("idle_rd_o", rd_o, 32'd0);
    end
  end
  initial begin
    rstn = 1'b0;
    req = 2'b00; lock = 2'b00;
    addr_0 = '0; addr_1 = '0; we_0 = 1'b0; we_1 = 1'b0; wd_0 = '0; wd_1 = '0;
    #12;
    chk("rst_addr", {27'd0, addr}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
    chk("rst_rd_o", rd_o, 32'd0);
    chk("rst_lock_own", {30'd0, lock_own}, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    // contention right after reset: R0 wins first tie, then alternate
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b00, 5'd1, 1'b0, 32'h1111_0001, 5'd2, 1'b1, 32'hA5A5_0002,
           i[0] ? 2'b10 : 2'b01, 2'b00, 1'b1);
    idle(2'b00);
    // single requester write
    step(2'b01, 2'b00, 5'h04, 1'b1, 32'h0000_00FF, 5'd0, 1'b0, 32'd0, 2'b01, 2'b00, 1'b1);
    idle(2'b00);
    // requester 1 reads address 0
    step(2'b10, 2'b00, 5'd0, 1'b0, 32'd0, 5'h00, 1'b0, 32'hDEAD_BEEF, 2'b10, 2'b00, 1'b1);
    idle(2'b00);
    // lock timeout: R0 locks then goes idle while R1 waits
    step(2'b01, 2'b01, 5'h08, 1'b1, 32'h0000_0010, 5'd0, 1'b0, 32'd0, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++)
      step(2'b10, 2'b00, 5'd0, 1'b0, 32'd0, 5'h0c, 1'b0, 32'd0,
           lk ? 2'b00 : 2'b10, lk ? 2'b01 : 2'b00, 1'b1);
    step(2'b10, 2'b00, 5'd0, 1'b0, 32'd0, 5'h0c, 1'b0, 32'd0, 2'b10, 2'b00, 1'b1);
    idle(2'b00);
    // locked burst of three from R0, released by the last transfer
    step(2'b11, 2'b01, 5'h04, 1'b1, 32'h0000_0001, 5'h08, 1'b0, 32'd0, 2'b01, 2'b00, 1'b1);
    step(2'b11, 2'b01, 5'h05, 1'b1, 32'h0000_0002, 5'h08, 1'b0, 32'd0,
         lk ? 2'b01 : 2'b10, lk ? 2'b01 : 2'b00, 1'b1);
    step(2'b11, 2'b00, 5'h06, 1'b1, 32'h0000_0003, 5'h08, 1'b0, 32'd0,
         2'b01, lk ? 2'b01 : 2'b00, 1'b1);
    step(2'b11, 2'b00, 5'h06, 1'b1, 32'h0000_0003, 5'h08, 1'b0, 32'd0, 2'b10, 2'b00, 1'b1);
    idle(2'b00);
    // reset the cycle after a locking accept
    step(2'b01, 2'b01, 5'h03, 1'b1, 32'h0000_0077, 5'd0, 1'b0, 32'd0, 2'b01, 2'b00, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b0;
    req = 2'b00; lock = 2'b00;
    #1;
    chk("mid_rst_rvalid", {30'd0, rvalid}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_lock_own", {30'd0, lock_own}, 32'd0);
    chk("mid_rst_addr", {27'd0, addr}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step(2'b11, 2'b00, 5'h02, 1'b0, 32'd0, 5'h01, 1'b0, 32'd0, 2'b01, 2'b00, 1'b1);
    idle(2'b00);
    idle(2'b00);
    @(posedge clk);
    #1;
    chk("gq_drained", gq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
